parity_frame_ctrl: RTL and testbench
====================================

// Module: parity_frame_ctrl
// PURPOSE
//  Serial frame sequencer around a parity generator: accepts a DATA_W-bit word over a
//  valid/ready handshake, shifts out start bit, data (LSB first), parity bit, stop bit.
//  Parity accumulates bit-serially as data shifts out. Sits between a word producer
//  and a single-wire serial sink; one frame in flight at a time.
// PARAMETERS
//  DATA_W   8  data bits per frame (>=1)
//  ODD      0  0: even parity (bit = XOR of data); 1: odd parity (bit = ~XOR of data)
//  BIT_CYC  1  clock cycles each serial bit is held (>=1); counter width $clog2(BIT_CYC+1)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  in_valid    in   1       producer has a word
//  in_ready    out  1       controller can accept; transfer when in_valid && in_ready
//  in_data     in   DATA_W  word; sampled only on transfer
//  tx_o        out  1       serial line, idle high, registered
//  busy        out  1       frame in progress (state != IDLE)
//  frame_done  out  1       one-cycle pulse, final cycle of stop bit
//  parity_o    out  1       parity bit of last/current frame, valid from PARITY state onward
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, tx_o=1, in_ready=1, busy=0, frame_done=0,
//   parity_o=0, shift reg and counters 0. Reset mid-frame aborts it at once: tx_o=1,
//   no frame_done, word discarded.
//  States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE: in_ready=1, tx_o=1. On transfer: latch in_data, clear parity acc, go START.
//   START: tx_o=0 for BIT_CYC cycles. DATA: tx_o=shift[0]; each bit held BIT_CYC
//   cycles; at bit end XOR bit into acc, shift right; after DATA_W bits go PARITY.
//   PARITY: tx_o = acc ^ ODD for BIT_CYC cycles; parity_o latched on entry.
//   STOP: tx_o=1 for BIT_CYC cycles; frame_done=1 in its last cycle; then IDLE.
//  in_ready=0 in every state except IDLE; in_valid/in_data ignored while busy.
//  Latency: tx_o falls the cycle after the transfer edge. Frame = (DATA_W+3)*BIT_CYC
//   cycles; min spacing between transfers = (DATA_W+3)*BIT_CYC+1 cycles.
//  Bit counter wraps exactly at DATA_W-1 -> 0; cycle counter at BIT_CYC-1 -> 0.
//   BIT_CYC=1 must give one cycle per bit with no idle gaps inside the frame.
//  parity_o holds its value through IDLE until next frame's PARITY entry.
// CONFIGURATION
//  TX_COUNT_EN defined: extra port frame_cnt out [15:0]; reset 0; +1 on each
//   frame_done; wraps 16'hFFFF -> 0. Aborted frames not counted.
//  TX_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package parity_frame_pkg: state typedef enum {IDLE,START,DATA,PARITY,STOP},
//   localparam widths for bit/cycle counters, IDLE_LINE=1'b1.
//  Sub-module parity_accum: 1-bit running XOR, ports clk, rst_n, clr, en, d, q;
//   async active-low reset to 0; clr priority over en.
//  Top holds FSM, shift register, counters, output registers.
// TESTING
//  1 DATA_W=8,BIT_CYC=1,ODD=0, send 8'hA5 -> tx_o per cycle after transfer:
//    0,1,0,1,0,0,1,0,1,0(parity),1(stop); frame_done on stop cycle; parity_o=0.
//  2 ODD=1, send 8'h00 -> parity bit 1; send 8'h01 -> parity bit 0.
//  3 in_valid held high, words 8'h0F,8'hF0 -> in_ready low for all 11 frame cycles,
//    second transfer exactly 1 cycle after first frame_done; both frames correct.
//  4 BIT_CYC=4, send 8'h81 -> each bit stable exactly 4 cycles, frame 44 cycles,
//    frame_done high 1 cycle only.
//  5 rst_n low during 3rd DATA bit -> tx_o=1, in_ready=1, busy=0 same instant;
//    no frame_done; next word after release sends normally.
//  6 TX_COUNT_EN, force frame_cnt to 16'hFFFF, complete one frame -> frame_cnt=0.

Source files
------------

// File: rtl/parity_frame_pkg.sv
// Package: parity_frame_pkg
// Shared types and helpers for the parity frame sequencer.
//   frame_state_e : frame sequencer states
//   IDLE_LINE     : level of the serial line when no frame is being sent
//   cnt_width()   : width of a counter that must hold values 0..max_val
//   parity_bit()  : final parity bit from the running XOR and the odd/even select
package parity_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } frame_state_e;

    localparam logic IDLE_LINE = 1'b1;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_BIT_CYC = 1;

    // Width of a counter covering 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Even parity is the plain XOR of the data; odd parity inverts it.
    function automatic logic parity_bit(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_ctrl_accum.sv
// Module: parity_accum
// One-bit running XOR used to build the frame parity bit-serially.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q
//   clr   : synchronous clear (wins over en)
//   en    : fold d into the running XOR this cycle
//   d     : data bit to fold in
//   q     : running XOR
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    logic acc_r;

    // Running XOR register; a clear at frame start overrides any pending fold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 1'b0;
        end else if (clr) begin
            acc_r <= 1'b0;
        end else if (en) begin
            acc_r <= acc_r ^ d;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign q = acc_r;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Module: parity_frame_ctrl
// Serial frame sequencer: takes a DATA_W-bit word over valid/ready and sends
// start bit (0), data LSB first, parity bit, stop bit (1), each held BIT_CYC
// cycles. Parity is accumulated bit-serially as data leaves the shift register.
// Optional feature: define TX_COUNT_EN to add the frame_cnt output, a 16-bit
// wrapping count of completed frames (aborted frames are not counted).
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_valid    : producer has a word
//   in_ready    : controller idle and able to accept a word
//   in_data     : word, sampled only on in_valid && in_ready
//   tx_o        : serial line, idle high, registered
//   busy        : frame in progress
//   frame_done  : one-cycle pulse in the last cycle of the stop bit
//   parity_o    : parity bit of the last/current frame, updated on PARITY entry
//   frame_cnt   : completed-frame count (TX_COUNT_EN only)
module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ODD     = 0,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_o,
    output logic              busy,
    output logic              frame_done,
    output logic              parity_o
`ifdef TX_COUNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int CYC_W = cnt_width(BIT_CYC);
    localparam int BIT_W = cnt_width(DATA_W - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic ODD_BIT = (ODD != 0) ? 1'b1 : 1'b0;

    frame_state_e      state_r, state_nxt_s;
    logic [CYC_W-1:0]  cyc_r, cyc_nxt_s;
    logic [BIT_W-1:0]  bit_r, bit_nxt_s;
    logic [DATA_W-1:0] shift_r, shift_nxt_s;
    logic              parity_r, par_nxt_s;
    logic              tx_r, tx_nxt_s;
    logic              in_ready_r, busy_r, done_r, done_nxt_s;
    logic              cyc_end_s;
    logic              acc_clr_s, acc_en_s, acc_q_s;

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr_s),
        .en    (acc_en_s),
        .d     (shift_r[0]),
        .q     (acc_q_s)
    );

    // Next-state logic: frame sequencing, bit/cycle counters, shifter, parity latch.
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = cyc_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = parity_r;
        acc_clr_s   = 1'b0;
        acc_en_s    = 1'b0;
        cyc_end_s   = (cyc_r == CYC_LAST);
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    shift_nxt_s = in_data;
                    acc_clr_s   = 1'b1;
                    cyc_nxt_s   = '0;
                    bit_nxt_s   = '0;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (cyc_end_s) begin
                    cyc_nxt_s   = '0;
                    state_nxt_s = DATA;
                end else begin
                    cyc_nxt_s = cyc_r + CYC_W'(1);
                end
            end
            DATA: begin
                if (cyc_end_s) begin
                    cyc_nxt_s   = '0;
                    acc_en_s    = 1'b1;
                    shift_nxt_s = shift_r >> 1;
                    if (bit_r == BIT_LAST) begin
                        bit_nxt_s   = '0;
                        state_nxt_s = PARITY;
                        // The accumulator only absorbs the last bit at this edge,
                        // so fold it in here to latch the final parity on entry.
                        par_nxt_s   = parity_bit(acc_q_s ^ shift_r[0], ODD_BIT);
                    end else begin
                        bit_nxt_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    cyc_nxt_s = cyc_r + CYC_W'(1);
                end
            end
            PARITY: begin
                if (cyc_end_s) begin
                    cyc_nxt_s   = '0;
                    state_nxt_s = STOP;
                end else begin
                    cyc_nxt_s = cyc_r + CYC_W'(1);
                end
            end
            STOP: begin
                if (cyc_end_s) begin
                    cyc_nxt_s   = '0;
                    state_nxt_s = IDLE;
                end else begin
                    cyc_nxt_s = cyc_r + CYC_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cyc_nxt_s   = '0;
                bit_nxt_s   = '0;
            end
        endcase
    end

    // Output look-ahead: outputs are registered, so decode them from the next state.
    always_comb begin
        tx_nxt_s   = IDLE_LINE;
        done_nxt_s = (state_nxt_s == STOP) && (cyc_nxt_s == CYC_LAST);
        case (state_nxt_s)
            IDLE:    tx_nxt_s = IDLE_LINE;
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shift_nxt_s[0];
            PARITY:  tx_nxt_s = par_nxt_s;
            STOP:    tx_nxt_s = IDLE_LINE;
            default: tx_nxt_s = IDLE_LINE;
        endcase
    end

    // Sequencer state, counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cyc_r   <= '0;
            bit_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cyc_r   <= cyc_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
        end
    end

    // Registered outputs; reset returns the line to idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r       <= IDLE_LINE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            parity_r   <= 1'b0;
        end else begin
            tx_r       <= tx_nxt_s;
            in_ready_r <= (state_nxt_s == IDLE);
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= done_nxt_s;
            parity_r   <= par_nxt_s;
        end
    end

    assign tx_o       = tx_r;
    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign parity_o   = parity_r;

`ifdef TX_COUNT_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'h0000;
        end else if (done_r) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
module tb_parity_frame_ctrl;

    localparam int BC_A = 1;
    localparam int BC_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       va, vb;
    logic [7:0] da, db;
    logic       rdy_a, tx_a, busy_a, done_a, par_a;
    logic       rdy_b, tx_b, busy_b, done_b, par_b;
`ifdef TX_COUNT_EN
    logic [15:0] cnt_a, cnt_b;
    int          ndone_a = 0;
`endif

    int  errs = 0;
    int  checks = 0;
    time t_done_a = 0;
    time t_xfer_a = 0;

    // {tx, done, parity_checked, parity}
    logic [3:0]  q_a[$];
    logic [3:0]  q_b[$];
    logic [10:0] fb_a, fb_b;

    parity_frame_ctrl #(.DATA_W(8), .ODD(0), .BIT_CYC(BC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a), .in_data(da),
        .tx_o(tx_a), .busy(busy_a), .frame_done(done_a), .parity_o(par_a)
`ifdef TX_COUNT_EN
        , .frame_cnt(cnt_a)
`endif
    );

    parity_frame_ctrl #(.DATA_W(8), .ODD(1), .BIT_CYC(BC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b), .in_data(db),
        .tx_o(tx_b), .busy(busy_b), .frame_done(done_b), .parity_o(par_b)
`ifdef TX_COUNT_EN
        , .frame_cnt(cnt_b)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Serial image of one frame: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic odd);
        logic [10:0] b;
        b[0]   = 1'b0;
        b[8:1] = d;
        b[9]   = (^d) ^ odd;
        b[10]  = 1'b1;
        return b;
    endfunction

    // Scoreboard push on each accepted word.
    always @(posedge clk) begin
        if (rst_n && va && rdy_a) begin
            fb_a = frame_bits(da, 1'b0);
            for (int j = 0; j < 11; j++)
                for (int c = 0; c < BC_A; c++)
                    q_a.push_back({fb_a[j], (j == 10 && c == BC_A - 1), (j >= 9), fb_a[9]});
        end
        if (rst_n && vb && rdy_b) begin
            fb_b = frame_bits(db, 1'b1);
            for (int j = 0; j < 11; j++)
                for (int c = 0; c < BC_B; c++)
                    q_b.push_back({fb_b[j], (j == 10 && c == BC_B - 1), (j >= 9), fb_b[9]});
        end
    end

    // Per-cycle comparison against the scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [3:0] e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check_val("a_tx", tx_a, e[3]);
            check_val("a_done", done_a, e[2]);
            check_val("a_ready", rdy_a, 1'b0);
            check_val("a_busy", busy_a, 1'b1);
            if (e[1]) check_val("a_parity_o", par_a, e[0]);
            if (e[2]) begin
                t_done_a = $time;
`ifdef TX_COUNT_EN
                ndone_a++;
`endif
            end
        end else begin
            check_val("a_idle_tx", tx_a, 1'b1);
            check_val("a_idle_done", done_a, 1'b0);
            check_val("a_idle_ready", rdy_a, 1'b1);
            check_val("a_idle_busy", busy_a, 1'b0);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check_val("b_tx", tx_b, e[3]);
            check_val("b_done", done_b, e[2]);
            check_val("b_ready", rdy_b, 1'b0);
            if (e[1]) check_val("b_parity_o", par_b, e[0]);
        end else begin
            check_val("b_idle_tx", tx_b, 1'b1);
            check_val("b_idle_done", done_b, 1'b0);
            check_val("b_idle_busy", busy_b, 1'b0);
        end
    end

    task automatic send_a(input logic [7:0] d, input logic keep);
        int n;
        @(negedge clk);
        va = 1'b1;
        da = d;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!rdy_a && n < 500);
        check_val("a_accept_timeout", (n < 500), 1'b1);
        t_xfer_a = $time;
        #1;
        if (!keep) va = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        @(negedge clk);
        vb = 1'b1;
        db = d;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!rdy_b && n < 500);
        check_val("b_accept_timeout", (n < 500), 1'b1);
        #1;
        vb = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", (n < 500), 1'b1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_tx", tx_a, 1'b1);
        check_val("rst_ready", rdy_a, 1'b1);
        check_val("rst_busy", busy_a, 1'b0);
        check_val("rst_parity", par_a, 1'b0);
        check_val("rst_parity_b", par_b, 1'b0);
        rst_n = 1'b1;

        // Even parity, one cycle per bit.
        send_a(8'hA5, 1'b0);
        wait_idle();
        check_val("a5_parity_hold", par_a, 1'b0);

        // Odd parity, four cycles per bit.
        send_b(8'h00);
        wait_idle();
        check_val("b00_parity_hold", par_b, 1'b1);
        send_b(8'h01);
        wait_idle();
        check_val("b01_parity_hold", par_b, 1'b0);
        send_b(8'h81);
        wait_idle();

        // Back-to-back with in_valid held high.
        send_a(8'h0F, 1'b1);
        send_a(8'hF0, 1'b0);
        check_val("b2b_gap", 32'(t_xfer_a - t_done_a), 32'd15);
        wait_idle();

        // Concurrent frames on both instances.
        fork
            send_a(8'h96, 1'b0);
            send_b(8'h7E);
        join
        wait_idle();

        // Abort during the third data bit.
        send_a(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_tx", tx_a, 1'b1);
        check_val("abort_ready", rdy_a, 1'b1);
        check_val("abort_busy", busy_a, 1'b0);
        check_val("abort_done", done_a, 1'b0);
        q_a.delete();
        q_b.delete();
`ifdef TX_COUNT_EN
        ndone_a = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send_a(8'h5A, 1'b0);
        wait_idle();

`ifdef TX_COUNT_EN
        check_val("frame_cnt", cnt_a, ndone_a);
        @(negedge clk);
        force dut_a.frame_cnt_r = 16'hFFFF;
        #1;
        release dut_a.frame_cnt_r;
        send_a(8'h11, 1'b0);
        wait_idle();
        check_val("frame_cnt_wrap", cnt_a, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
